// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter that serialises node requests onto the single shared memory bank,
// rebasing node-local addresses into the shared window.
module shared_mem_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter logic [31:0] SHARED_BASE = 32'h0000_4000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_read,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [32*NUM_REQ-1:0]  req_address,
  input  logic [32*NUM_REQ-1:0]  req_writedata,
  output logic [31:0]            req_readdata,
  output logic [NUM_REQ-1:0]     req_busywait,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [31:0]            mem_address,
  output logic [31:0]            mem_writedata,
  input  logic [31:0]            mem_readdata,
  input  logic                   mem_busywait
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]             state;
  logic [GW-1:0]          grant;
  logic [GW-1:0]          last;
  logic                   op_write;
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata;

  logic [NUM_REQ-1:0]     pending;
  logic [2*NUM_REQ-1:0]   dbl;
  logic [NUM_REQ-1:0]     rot;
  logic [GW-1:0]          start;
  logic [GW-1:0]          pick;
  logic                   found;
  int                     s;
  logic [31:0]            sel_addr;
  logic [31:0]            sel_wdata;
  logic                   sel_write;
  logic                   unused_addr_bits;

  assign pending = req_read | req_write;

  // Rotate the request vector so the search always starts just above the last-served node.
  always_comb begin
    start     = (last == LAST_INIT) ? '0 : last + 1'b1;
    dbl       = {pending, pending};
    rot       = NUM_REQ'(dbl >> start);
    found     = 1'b0;
    pick      = '0;
    s         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        s     = int'(start) + i;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        pick  = GW'(s);
      end
    end
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick == GW'(j)) begin
        sel_addr  = req_address[32*j +: 32];
        sel_wdata = req_writedata[32*j +: 32];
        sel_write = req_write[j];
      end
    end
  end

  assign unused_addr_bits = ^sel_addr[31:9];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      last     <= LAST_INIT;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= pick;
            op_write <= sel_write;
            addr_q   <= SHARED_BASE + {23'd0, sel_addr[8:0]};
            wdata_q  <= sel_wdata;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!mem_busywait) begin
            if (!op_write) rdata <= mem_readdata;
            state <= DONE;
          end
        end
        DONE: begin
          last  <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the granted node sees its stall released, and only for the single DONE cycle.
  always_comb begin
    req_busywait = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_busywait[i] = pending[i] & ~((state == DONE) && (grant == GW'(i)));
    end
  end

  assign mem_read      = (state == ACCESS) & ~op_write;
  assign mem_write     = (state == ACCESS) &  op_write;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign req_readdata  = rdata;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-timeline model of the arbiter.
module tb_shared_mem_arbiter;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0000_4000;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_read;
  logic [N-1:0]    req_write;
  logic [32*N-1:0] req_address;
  logic [32*N-1:0] req_writedata;
  logic [31:0]     req_readdata;
  logic [N-1:0]    req_busywait;
  logic            mem_read;
  logic            mem_write;
  logic [31:0]     mem_address;
  logic [31:0]     mem_writedata;
  logic [31:0]     mem_readdata;
  logic            mem_busywait;

  int checks = 0;
  int fails  = 0;

  logic [31:0] bank    [512];
  logic [31:0] ref_mem [512];

  always #5 clk = ~clk;

  shared_mem_arbiter #(.NUM_REQ(N), .SHARED_BASE(BASE)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_writedata(req_writedata),
    .req_readdata(req_readdata), .req_busywait(req_busywait),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    req_read[n]                = rd;
    req_write[n]               = wr;
    req_address[32*n +: 32]    = a;
    req_writedata[32*n +: 32]  = d;
  endtask

  task automatic clear_reqs();
    req_read      = '0;
    req_write     = '0;
    req_address   = '0;
    req_writedata = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b0;
    clear_reqs();
    mem_busywait = 1'b0;
    mem_readdata = '0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_reqs();
    mem_busywait = 1'b0;
    mem_readdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_read !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_write: got %b want 0", mem_write); end
    checks++; if (mem_address !== 32'h0) begin fails++; $display("[TB] FAIL reset_mem_address: got %h want 0", mem_address); end
    checks++; if (mem_writedata !== 32'h0) begin fails++; $display("[TB] FAIL reset_mem_writedata: got %h want 0", mem_writedata); end
    checks++; if (req_readdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_readdata: got %h want 0", req_readdata); end
    checks++; if (req_busywait !== 4'b0000) begin fails++; $display("[TB] FAIL reset_busywait: got %b want 0000", req_busywait); end
    set_req(1, 1'b1, 1'b0, 32'd1030, 32'd0);
    #1;
    checks++; if (req_busywait !== 4'b0010) begin fails++; $display("[TB] FAIL reset_busywait_req: got %b want 0010", req_busywait); end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(2, 1'b1, 1'b0, 32'd1029, 32'd0);
    mem_readdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (req_busywait !== 4'b0100) begin fails++; $display("[TB] FAIL single_c0_busywait: got %b want 0100", req_busywait); end
    next_cycle(); @(negedge clk);
    checks++; if (mem_read !== 1'b1) begin fails++; $display("[TB] FAIL single_c1_mem_read: got %b want 1", mem_read); end
    checks++; if (mem_address !== 32'h4005) begin fails++; $display("[TB] FAIL single_c1_addr: got %h want 00004005", mem_address); end
    checks++; if (req_busywait !== 4'b0100) begin fails++; $display("[TB] FAIL single_c1_busywait: got %b want 0100", req_busywait); end
    next_cycle(); @(negedge clk);
    checks++; if (req_busywait !== 4'b0000) begin fails++; $display("[TB] FAIL single_c2_busywait: got %b want 0000", req_busywait); end
    checks++; if (req_readdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL single_c2_rdata: got %h want deadbeef", req_readdata); end
    checks++; if (mem_read !== 1'b0) begin fails++; $display("[TB] FAIL single_c2_mem_read: got %b want 0", mem_read); end
    next_cycle();
    clear_reqs();
    mem_readdata = '0;
    @(negedge clk);
    checks++; if (mem_read !== 1'b0 || req_busywait !== 4'b0000) begin fails++; $display("[TB] FAIL single_c3_idle: read %b bw %b want 0 0000", mem_read, req_busywait); end
  endtask

  task automatic test_write_wait();
    int wr_cycles;
    int done_c;
    wr_cycles = 0;
    done_c    = -1;
    next_cycle();
    set_req(1, 1'b0, 1'b1, 32'd1535, 32'h12345678);
    mem_busywait = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 4) mem_busywait = 1'b0;
      if (done_c >= 0 && c == done_c + 1) clear_reqs();
      @(negedge clk);
      if (mem_write) begin
        wr_cycles++;
        checks++;
        if (mem_address !== 32'h41FF || mem_writedata !== 32'h12345678) begin
          fails++; $display("[TB] FAIL write_addr_data: got %h/%h want 000041ff/12345678", mem_address, mem_writedata);
        end
      end
      if (done_c < 0 && req_write[1] && !req_busywait[1]) done_c = c;
    end
    checks++; if (wr_cycles != 4) begin fails++; $display("[TB] FAIL write_strobe_len: got %0d want 4", wr_cycles); end
    checks++; if (done_c + 1 != 6) begin fails++; $display("[TB] FAIL write_latency: got %0d want 6", done_c + 1); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_bw;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'd1024 + 32'(i * 10), 32'd0);
    mem_readdata = 32'hA000_0000;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      exp_bw = 4'hF;
      if (c >= 2 && (c - 2) % 3 == 0) exp_bw = ~(4'b0001 << (((c - 2) / 3) % 4));
      checks++;
      if (req_busywait !== exp_bw) begin fails++; $display("[TB] FAIL rr_busywait c%0d: got %b want %b", c, req_busywait, exp_bw); end
      if (c % 3 == 1) begin
        checks++;
        if (mem_read !== 1'b1 || mem_address !== BASE + 32'((((c - 1) / 3) % 4) * 10)) begin
          fails++; $display("[TB] FAIL rr_grant c%0d: read %b addr %h want 1 %h", c, mem_read, mem_address, BASE + 32'((((c - 1) / 3) % 4) * 10));
        end
      end
    end
    next_cycle();
    clear_reqs();
    next_cycle();
  endtask

  task automatic test_address_wrap();
    set_req(0, 1'b1, 1'b0, 32'd1624, 32'd0);
    next_cycle(); @(negedge clk);
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h4058) begin fails++; $display("[TB] FAIL wrap_600: read %b addr %h want 1 00004058", mem_read, mem_address); end
    next_cycle();
    next_cycle();
    clear_reqs();
    set_req(3, 1'b0, 1'b1, 32'h0001_07FF, 32'h0BAD_F00D);
    next_cycle(); @(negedge clk);
    checks++; if (mem_write !== 1'b1 || mem_address !== 32'h41FF) begin fails++; $display("[TB] FAIL wrap_high_bits: write %b addr %h want 1 000041ff", mem_write, mem_address); end
    next_cycle();
    next_cycle();
    clear_reqs();
  endtask

  task automatic test_reset_mid_op();
    next_cycle();
    set_req(2, 1'b1, 1'b0, 32'd1044, 32'd0);
    mem_busywait = 1'b1;
    mem_readdata = 32'hCAFEF00D;
    next_cycle(); @(negedge clk);
    checks++; if (mem_read !== 1'b1) begin fails++; $display("[TB] FAIL rst_mid_c1_read: got %b want 1", mem_read); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_read !== 1'b1) begin fails++; $display("[TB] FAIL rst_mid_c2_read: got %b want 1", mem_read); end
    next_cycle();
    reset = 1'b1;
    mem_busywait = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'd1054, 32'd0);
    @(negedge clk);
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("[TB] FAIL rst_mid_strobes: read %b write %b want 0 0", mem_read, mem_write); end
    checks++; if (req_readdata !== 32'h0) begin fails++; $display("[TB] FAIL rst_mid_rdata: got %h want 0", req_readdata); end
    checks++; if (req_busywait !== 4'b0101) begin fails++; $display("[TB] FAIL rst_mid_busywait: got %b want 0101", req_busywait); end
    next_cycle(); @(negedge clk);
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h401E) begin fails++; $display("[TB] FAIL rst_mid_first_grant: read %b addr %h want 1 0000401e", mem_read, mem_address); end
    next_cycle(); @(negedge clk);
    checks++; if (req_busywait !== 4'b0100) begin fails++; $display("[TB] FAIL rst_mid_node0_done: got %b want 0100", req_busywait); end
    next_cycle();
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    next_cycle(); @(negedge clk);
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h4014) begin fails++; $display("[TB] FAIL rst_mid_regrant: read %b addr %h want 1 00004014", mem_read, mem_address); end
    next_cycle(); @(negedge clk);
    checks++; if (req_busywait !== 4'b0000 || req_readdata !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL rst_mid_node2_done: bw %b rdata %h want 0000 cafef00d", req_busywait, req_readdata); end
    next_cycle();
    clear_reqs();
  endtask

  task automatic test_abandoned();
    next_cycle();
    set_req(3, 1'b1, 1'b0, 32'd1031, 32'd0);
    mem_readdata = 32'h55AA55AA;
    @(negedge clk);
    checks++; if (req_busywait !== 4'b1000) begin fails++; $display("[TB] FAIL abandon_c0_busywait: got %b want 1000", req_busywait); end
    next_cycle();
    set_req(3, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(0, 1'b1, 1'b0, 32'd1032, 32'd0);
    @(negedge clk);
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h4007) begin fails++; $display("[TB] FAIL abandon_c1_access: read %b addr %h want 1 00004007", mem_read, mem_address); end
    checks++; if (req_busywait !== 4'b0001) begin fails++; $display("[TB] FAIL abandon_c1_busywait: got %b want 0001", req_busywait); end
    next_cycle();
    mem_readdata = 32'h11112222;
    @(negedge clk);
    checks++; if (req_readdata !== 32'h55AA55AA || mem_read !== 1'b0) begin fails++; $display("[TB] FAIL abandon_c2_done: rdata %h read %b want 55aa55aa 0", req_readdata, mem_read); end
    checks++; if (req_busywait !== 4'b0001) begin fails++; $display("[TB] FAIL abandon_c2_busywait: got %b want 0001", req_busywait); end
    next_cycle(); @(negedge clk);
    checks++; if (req_busywait !== 4'b0001 || mem_read !== 1'b0) begin fails++; $display("[TB] FAIL abandon_c3_idle: bw %b read %b want 0001 0", req_busywait, mem_read); end
    next_cycle(); @(negedge clk);
    checks++; if (mem_read !== 1'b1 || mem_address !== 32'h4008) begin fails++; $display("[TB] FAIL abandon_node0_grant: read %b addr %h want 1 00004008", mem_read, mem_address); end
    next_cycle(); @(negedge clk);
    checks++; if (req_busywait !== 4'b0000 || req_readdata !== 32'h11112222) begin fails++; $display("[TB] FAIL abandon_node0_done: bw %b rdata %h want 0000 11112222", req_busywait, req_readdata); end
    next_cycle();
    clear_reqs();
  endtask

  // Transaction-level model: each service is one idle cycle, 1+wait access cycles, one done cycle.
  task automatic test_random();
    bit          act [N];
    bit          nwr [N];
    logic [31:0] naddr [N];
    logic [31:0] ndata [N];
    bit          done_flag [N];
    bit          m_busy, m_wr, in_access, in_done;
    int          cyc, m_t, m_w, m_win, m_last, m_off, win;
    logic [31:0] m_data;
    logic [N-1:0] exp_bw;
    for (int i = 0; i < 512; i++) begin bank[i] = $urandom; ref_mem[i] = bank[i]; end
    do_reset();
    m_last = N - 1; m_busy = 1'b0; cyc = 0; m_t = 0; m_w = 0; m_win = 0; m_wr = 1'b0; m_off = 0; m_data = '0;
    for (int i = 0; i < N; i++) begin act[i] = 1'b0; done_flag[i] = 1'b0; nwr[i] = 1'b0; naddr[i] = '0; ndata[i] = '0; end
    for (int step = 0; step < 400; step++) begin
      next_cycle();
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (done_flag[i]) begin
          act[i] = 1'b0; done_flag[i] = 1'b0;
        end else if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i]   = 1'b1;
          nwr[i]   = ($urandom_range(0, 1) == 1);
          naddr[i] = 32'h400 + 32'($urandom_range(0, 1023)) + (32'($urandom_range(0, 15)) << 12);
          ndata[i] = $urandom;
        end
        req_write[i] = act[i] && nwr[i];
        req_read[i]  = act[i] && (!nwr[i] || ($urandom_range(0, 1) == 1));
        req_address[32*i +: 32]   = act[i] ? naddr[i] : $urandom;
        req_writedata[32*i +: 32] = act[i] ? ndata[i] : $urandom;
      end
      if (m_busy && cyc > m_t + 2 + m_w) m_busy = 1'b0;
      if (!m_busy) begin
        win = -1;
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (win < 0 && act[j]) win = j;
        end
        if (win >= 0) begin
          m_busy = 1'b1; m_t = cyc; m_w = int'($urandom_range(0, 3)); m_win = win;
          m_wr = nwr[win]; m_off = int'(naddr[win] % 32'd512); m_data = ndata[win];
        end
      end
      in_access    = m_busy && cyc >= m_t + 1 && cyc <= m_t + 1 + m_w;
      in_done      = m_busy && cyc == m_t + 2 + m_w;
      mem_busywait = in_access ? (cyc <= m_t + m_w) : ($urandom_range(0, 1) == 1);
      mem_readdata = bank[mem_address[8:0]];
      @(negedge clk);
      checks++;
      if (mem_read !== (in_access && !m_wr) || mem_write !== (in_access && m_wr)) begin
        fails++; $display("[TB] FAIL rand_strobes cyc%0d: read %b write %b want %b %b", cyc, mem_read, mem_write, in_access && !m_wr, in_access && m_wr);
      end
      if (in_access) begin
        checks++;
        if (mem_address !== BASE + 32'(m_off)) begin fails++; $display("[TB] FAIL rand_addr cyc%0d: got %h want %h", cyc, mem_address, BASE + 32'(m_off)); end
        if (m_wr) begin
          checks++;
          if (mem_writedata !== m_data) begin fails++; $display("[TB] FAIL rand_wdata cyc%0d: got %h want %h", cyc, mem_writedata, m_data); end
        end
      end
      for (int i = 0; i < N; i++) exp_bw[i] = act[i] && !(in_done && m_win == i);
      checks++;
      if (req_busywait !== exp_bw) begin fails++; $display("[TB] FAIL rand_busywait cyc%0d: got %b want %b", cyc, req_busywait, exp_bw); end
      if (in_done && !m_wr) begin
        checks++;
        if (req_readdata !== ref_mem[m_off]) begin fails++; $display("[TB] FAIL rand_rdata cyc%0d: got %h want %h", cyc, req_readdata, ref_mem[m_off]); end
      end
      if (in_done) begin
        if (m_wr) ref_mem[m_off] = m_data;
        m_last = m_win;
        done_flag[m_win] = 1'b1;
      end
      if (mem_write && !mem_busywait) bank[mem_address[8:0]] = mem_writedata;
    end
    next_cycle();
    clear_reqs();
    mem_busywait = 1'b0;
    repeat (6) next_cycle();
  endtask

  initial begin
    reset = 1'b0;
    clear_reqs();
    mem_busywait = 1'b0;
    mem_readdata = '0;
    test_reset();
    test_single_read();
    test_write_wait();
    test_round_robin();
    test_address_wrap();
    test_reset_mid_op();
    test_abandoned();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
